// File: rtl/mdu_ctrl.sv
// Sequencer between the EXU and the multi-cycle multiply/divide units: latches one request,
// drives the unit handshake, stalls the pipeline, resolves div-by-zero and repeated divisions locally.
module mdu_ctrl #(
    parameter int XLEN     = 64,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [1:0]      op_i,
    input  logic            unsign_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            mul_valid_o,
    output logic            div_valid_o,
    output logic            div_signed_o,
    output logic            word_o,
    output logic [XLEN-1:0] opa_o,
    output logic [XLEN-1:0] opb_o,
    input  logic            mul_data_ok_i,
    input  logic [XLEN-1:0] mul_res_i,
    input  logic            div_data_ok_i,
    input  logic [XLEN-1:0] div_res_i,
    input  logic [XLEN-1:0] rem_res_i,
    output logic            stall_req_o,
    output logic            res_valid_o,
    output logic [XLEN-1:0] res_o
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_BUSY,
        DIV_BUSY,
        DONE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            unit_div;
    logic            rem_sel;
    logic [XLEN-1:0] res_q;

    logic            cache_valid;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic            cache_uns;
    logic            cache_word;
    logic [XLEN-1:0] cache_quo;
    logic [XLEN-1:0] cache_rem;

    logic            is_div_req;
    logic            is_rem_req;
    logic            div_by_zero;
    logic            cache_hit;
    logic            accept;
    logic            local_res;
    logic            cache_write;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Divide-by-zero results: quotient is all ones, remainder is the dividend.
    function automatic logic [XLEN-1:0] div0_result(input logic       rem,
                                                    input logic       word,
                                                    input logic [XLEN-1:0] dividend);
        if (!rem) begin
            return '1;
        end else if (word) begin
            return sext32(dividend[31:0]);
        end else begin
            return dividend;
        end
    endfunction

    assign is_div_req  = (op_i == 2'd1) || (op_i == 2'd2);
    assign is_rem_req  = (op_i == 2'd2);
    assign div_by_zero = word_i ? (src2_i[31:0] == 32'd0) : (src2_i == '0);
    assign cache_hit   = CACHE_EN && cache_valid && (src1_i == cache_a) && (src2_i == cache_b)
                         && (unsign_i == cache_uns) && (word_i == cache_word);
    assign accept      = (state == IDLE) && req_valid_i && !flush_i;
    assign local_res   = is_div_req && (div_by_zero || cache_hit);

    // A drained division still completes correctly, so its result is worth caching.
    assign cache_write = div_data_ok_i && ((state == DIV_BUSY) || ((state == DRAIN) && unit_div));

    assign res_o = res_q;

    always_comb begin
        state_nxt   = state;
        stall_req_o = 1'b0;
        mul_valid_o = 1'b0;
        div_valid_o = 1'b0;
        res_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                stall_req_o = req_valid_i && !flush_i;
                if (accept) begin
                    if (local_res) begin
                        state_nxt = DONE;
                    end else if (is_div_req) begin
                        state_nxt = DIV_BUSY;
                    end else begin
                        state_nxt = MUL_BUSY;
                    end
                end
            end
            MUL_BUSY: begin
                stall_req_o = 1'b1;
                mul_valid_o = 1'b1;
                if (mul_data_ok_i) begin
                    state_nxt = flush_i ? IDLE : DONE;
                end else if (flush_i) begin
                    state_nxt = DRAIN;
                end
            end
            DIV_BUSY: begin
                stall_req_o = 1'b1;
                div_valid_o = 1'b1;
                if (div_data_ok_i) begin
                    state_nxt = flush_i ? IDLE : DONE;
                end else if (flush_i) begin
                    state_nxt = DRAIN;
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                state_nxt   = IDLE;
            end
            DRAIN: begin
                // Units cannot abort: hold the request until the in-flight result is dropped.
                stall_req_o = req_valid_i;
                mul_valid_o = !unit_div;
                div_valid_o = unit_div;
                if (unit_div ? div_data_ok_i : mul_data_ok_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cache_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cache_write) begin
                cache_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_o        <= '0;
            opb_o        <= '0;
            word_o       <= 1'b0;
            div_signed_o <= 1'b0;
            unit_div     <= 1'b0;
            rem_sel      <= 1'b0;
            res_q        <= '0;
        end else begin
            if (accept) begin
                opa_o        <= src1_i;
                opb_o        <= src2_i;
                word_o       <= word_i;
                div_signed_o <= ~unsign_i;
                unit_div     <= is_div_req;
                rem_sel      <= is_rem_req;
                if (is_div_req && div_by_zero) begin
                    res_q <= div0_result(is_rem_req, word_i, src1_i);
                end else if (is_div_req && cache_hit) begin
                    res_q <= is_rem_req ? cache_rem : cache_quo;
                end
            end
            if ((state == MUL_BUSY) && mul_data_ok_i && !flush_i) begin
                res_q <= mul_res_i;
            end
            if ((state == DIV_BUSY) && div_data_ok_i && !flush_i) begin
                res_q <= rem_sel ? rem_res_i : div_res_i;
            end
        end
    end

    // Cache payload is qualified by cache_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cache_write) begin
            cache_a    <= opa_o;
            cache_b    <= opb_o;
            cache_uns  <= ~div_signed_o;
            cache_word <= word_o;
            cache_quo  <= div_res_i;
            cache_rem  <= rem_res_i;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: behavioural multiplier/divider responders, RISC-V M-extension
// reference results, directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_mdu_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic [1:0]      op;
    logic            unsign;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            mul_valid;
    logic            div_valid;
    logic            div_signed;
    logic            word_o;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            mul_data_ok;
    logic [XLEN-1:0] mul_res;
    logic            div_data_ok;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] rem_res;
    logic            stall;
    logic            res_valid;
    logic [XLEN-1:0] res;

    mdu_ctrl #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .op_i         (op),
        .unsign_i     (unsign),
        .word_i       (word),
        .src1_i       (src1),
        .src2_i       (src2),
        .flush_i      (flush),
        .mul_valid_o  (mul_valid),
        .div_valid_o  (div_valid),
        .div_signed_o (div_signed),
        .word_o       (word_o),
        .opa_o        (opa),
        .opb_o        (opb),
        .mul_data_ok_i(mul_data_ok),
        .mul_res_i    (mul_res),
        .div_data_ok_i(div_data_ok),
        .div_res_i    (div_res),
        .rem_res_i    (rem_res),
        .stall_req_o  (stall),
        .res_valid_o  (res_valid),
        .res_o        (res)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int          mul_lat = 3;
    int          div_lat = 3;
    int          mul_cnt = 0;
    int          div_cnt = 0;

    bit          cache_ok = 1'b0;
    logic [63:0] cache_a, cache_b;
    logic        cache_u, cache_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // RISC-V M-extension result of one instruction.
    function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic u, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        logic        rem;
        a32 = a[31:0];
        b32 = b[31:0];
        rem = (f_op == 2'd2);
        if (f_op != 2'd1 && f_op != 2'd2) begin
            r   = a * b;
            r32 = a32 * b32;
            return w ? {{32{r32[31]}}, r32} : r;
        end
        if (w) begin
            if (b32 == 32'd0)                                   r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (u)                                         r32 = rem ? (a32 % b32) : (a32 / b32);
            else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
            else if (rem)                                       r32 = 32'($signed(a32) % $signed(b32));
            else                                                r32 = 32'($signed(a32) / $signed(b32));
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                              r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (u)                                                  r = rem ? (a % b) : (a / b);
        else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = rem ? 64'd0 : a;
        else if (rem)                                                r = 64'($signed(a) % $signed(b));
        else                                                         r = 64'($signed(a) / $signed(b));
        return r;
    endfunction

    // Multiplier model: answers after mul_lat cycles of a held request.
    initial begin
        mul_data_ok = 1'b0;
        mul_res     = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                mul_cnt = 0; mul_data_ok = 1'b0;
            end else if (mul_data_ok) begin
                mul_cnt = 0; mul_data_ok = 1'b0;
            end else if (mul_valid) begin
                mul_cnt++;
                if (mul_cnt >= mul_lat) begin
                    mul_data_ok = 1'b1;
                    mul_res     = ref_result(2'd0, 1'b0, word_o, opa, opb);
                end
            end
        end
    end

    // Divider model.
    initial begin
        div_data_ok = 1'b0;
        div_res     = '0;
        rem_res     = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                div_cnt = 0; div_data_ok = 1'b0;
            end else if (div_data_ok) begin
                div_cnt = 0; div_data_ok = 1'b0;
            end else if (div_valid) begin
                div_cnt++;
                if (div_cnt >= div_lat) begin
                    div_data_ok = 1'b1;
                    div_res     = ref_result(2'd1, ~div_signed, word_o, opa, opb);
                    rem_res     = ref_result(2'd2, ~div_signed, word_o, opa, opb);
                end
            end
        end
    end

    // Result monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                check("valid_exclusive", mul_valid & div_valid, 1'b0);
                if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got res_valid_o=1 res_o=0x%0h, want no result", res);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("res_o", res, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want bench to finish");
        $fatal(1, "bench timeout");
    end

    task automatic drive(input logic [1:0] f_op, input logic u, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1;
        op        = f_op;
        unsign    = u;
        word      = w;
        src1      = a;
        src2      = b;
    endtask

    task automatic note_div(input logic [63:0] a, input logic [63:0] b, input logic u, input logic w);
        cache_ok = 1'b1;
        cache_a  = a;
        cache_b  = b;
        cache_u  = u;
        cache_w  = w;
    endtask

    task automatic predict(input logic [1:0] f_op, input logic u, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           output int lat, output int mcyc, output int dcyc);
        bit is_div, z, hit;
        is_div = (f_op == 2'd1) || (f_op == 2'd2);
        z      = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        hit    = cache_ok && (a == cache_a) && (b == cache_b) && (u == cache_u) && (w == cache_w);
        exp_q.push_back(ref_result(f_op, u, w, a, b));
        if (!is_div) begin
            lat = mul_lat + 1; mcyc = mul_lat; dcyc = 0;
        end else if (z || hit) begin
            lat = 1; mcyc = 0; dcyc = 0;
        end else begin
            lat = div_lat + 1; mcyc = 0; dcyc = div_lat;
            note_div(a, b, u, w);
        end
    endtask

    // Called at the accept-cycle sample; follows the transaction to its result.
    task automatic wait_result(input string name, input int lat, input int mcyc, input int dcyc);
        int k, mc, dc;
        bit got;
        k = 0; mc = 0; dc = 0; got = 1'b0;
        while (!got && k < 60) begin
            @(negedge clk); #2;
            k++;
            if (mul_valid) mc++;
            if (div_valid) dc++;
            if (res_valid) begin
                got = 1'b1;
                check({name, "_stall_at_result"}, stall, 1'b0);
            end else begin
                check({name, "_stall_busy"}, stall, 1'b1);
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no res_valid_o in %0d cycles, want latency %0d", name, k, lat);
        end else begin
            check({name, "_latency"}, k, lat);
        end
        check({name, "_mul_cycles"}, mc, mcyc);
        check({name, "_div_cycles"}, dc, dcyc);
    endtask

    task automatic issue(input string name, input logic [1:0] f_op, input logic u, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        int lat, mc, dc;
        @(negedge clk);
        drive(f_op, u, w, a, b);
        flush = 1'b0;
        predict(f_op, u, w, a, b, lat, mc, dc);
        #2;
        check({name, "_stall_accept"}, stall, 1'b1);
        wait_result(name, lat, mc, dc);
    endtask

    logic [1:0]  r_op;
    logic        r_u, r_w, last_u, last_w;
    logic [63:0] r_a, r_b, last_a, last_b;
    int          dcount, t4_lat, t4_mc, t4_dc;

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; op = '0;
        unsign = 1'b0; word = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_stall", stall, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_mul_valid", mul_valid, 1'b0);
        check("rst_div_valid", div_valid, 1'b0);
        check("rst_res", res, 64'd0);
        check("rst_opa", opa, 64'd0);
        check("rst_opb", opb, 64'd0);
        check("rst_word", word_o, 1'b0);
        check("rst_div_signed", div_signed, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // MUL 7*6, three-cycle multiplier
        mul_lat = 3;
        issue("t1_mul", 2'd0, 1'b0, 1'b0, 64'd7, 64'd6);

        // DIV -20/3 through the unit, then REM served from the cache
        div_lat = 5;
        issue("t2_div", 2'd1, 1'b0, 1'b0, -64'sd20, 64'd3);
        issue("t2_rem_hit", 2'd2, 1'b0, 1'b0, -64'sd20, 64'd3);

        // DIVUW / REMUW with a zero low word in the divisor
        issue("t3_divuw0", 2'd1, 1'b1, 1'b1, 64'd5, 64'h1_0000_0000);
        issue("t3_remuw0", 2'd2, 1'b1, 1'b1, 64'd5, 64'h1_0000_0000);

        // Flush two cycles into a ten-cycle division; a new MUL waits through DRAIN
        div_lat = 10;
        mul_lat = 2;
        @(negedge clk);
        drive(2'd1, 1'b0, 1'b0, 64'd100, 64'd7);
        flush = 1'b0;
        #2;
        check("t4_stall_accept", stall, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check("t4_div_valid_1", div_valid, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        #2;
        check("t4_div_valid_flush", div_valid, 1'b1);
        check("t4_stall_flush", stall, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        drive(2'd0, 1'b0, 1'b0, 64'd3, 64'd5);
        #2;
        dcount = 2;
        for (int k = 3; k < 40; k++) begin
            if (k > 3) begin
                @(negedge clk); #2;
            end
            if (!div_valid) break;
            dcount++;
            check("t4_drain_stall", stall, 1'b1);
            check("t4_drain_no_result", res_valid, 1'b0);
            check("t4_drain_no_mul", mul_valid, 1'b0);
        end
        check("t4_div_valid_cycles", dcount, 10);
        check("t4_mul_accept_stall", stall, 1'b1);
        note_div(64'd100, 64'd7, 1'b0, 1'b0);
        predict(2'd0, 1'b0, 1'b0, 64'd3, 64'd5, t4_lat, t4_mc, t4_dc);
        wait_result("t4_mul", t4_lat, t4_mc, t4_dc);
        issue("t4_rem_after_drain", 2'd2, 1'b0, 1'b0, 64'd100, 64'd7);

        // Reset in DIV_BUSY invalidates the cache
        div_lat = 8;
        @(negedge clk);
        drive(2'd1, 1'b0, 1'b0, 64'd1000, -64'sd7);
        #2;
        check("t5_stall_accept", stall, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check("t5_div_valid_busy", div_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("t5_div_valid_after_rst", div_valid, 1'b0);
        check("t5_stall_after_rst", stall, 1'b0);
        check("t5_res_valid_after_rst", res_valid, 1'b0);
        cache_ok = 1'b0;
        issue("t5_repeat_div", 2'd1, 1'b0, 1'b0, 64'd100, 64'd7);

        // Request together with flush in IDLE
        @(negedge clk);
        drive(2'd0, 1'b0, 1'b0, 64'd9, 64'd9);
        flush = 1'b1;
        #2;
        check("t6_stall", stall, 1'b0);
        check("t6_mul_valid", mul_valid, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        #2;
        check("t6_mul_valid_next", mul_valid, 1'b0);
        check("t6_div_valid_next", div_valid, 1'b0);
        check("t6_res_valid_next", res_valid, 1'b0);
        issue("t6_after", 2'd3, 1'b0, 1'b1, 64'hFFFF_FFFF_0001_0000, 64'h0000_0001_0001_0000);

        // Randomized traffic
        last_a = 64'd100; last_b = 64'd7; last_u = 1'b0; last_w = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_u  = 1'($urandom_range(0, 1));
            r_w  = 1'($urandom_range(0, 1));
            r_a  = {$urandom, $urandom};
            r_b  = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: r_b = 64'(int'($urandom_range(0, 40)) - 20);
                1: r_b = $urandom_range(0, 1) ? 64'd0 : {$urandom, 32'd0};
                2: begin
                    r_a = r_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
                    r_b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3, 4: begin
                    r_a = last_a;
                    r_b = last_b;
                    if ($urandom_range(0, 3) != 0) begin
                        r_u = last_u;
                        r_w = last_w;
                    end
                end
                default: ;
            endcase
            mul_lat = $urandom_range(1, 6);
            div_lat = $urandom_range(1, 6);
            issue("rand", r_op, r_u, r_w, r_a, r_b);
            last_a = r_a; last_b = r_b; last_u = r_u; last_w = r_w;
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
